// File: rtl/serial_word_arbiter.sv
// serial_word_arbiter: round-robin shared deserializer for n_ch serial lanes with idle-timeout abort
module serial_word_arbiter #(
  parameter int width   = 8,
  parameter int n_ch    = 4,
  parameter int timeout = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [n_ch-1:0]           serial_valid,
  input  logic [n_ch-1:0]           serial_data,
  output logic [n_ch-1:0]           serial_ready,
  output logic                      busy,
  output logic                      parallel_valid,
  output logic [width-1:0]          parallel_data,
  output logic [$clog2(n_ch)-1:0]   parallel_ch,
  output logic                      err,
  output logic [$clog2(n_ch)-1:0]   err_ch
);
  localparam int cw = $clog2(n_ch);
  localparam int bw = $clog2(width);
  localparam int iw = timeout > 1 ? $clog2(timeout) : 1;

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;

  logic [cw-1:0]    grant, last_grant, pick, idx;
  logic             found, acc, done, abort;
  logic [width-1:0] shift, shift_n;
  logic [bw-1:0]    bit_cnt;
  logic [iw-1:0]    idle_cnt;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= n_ch; i++) begin
      idx = cw'((int'(last_grant) + i) % n_ch);
      if (!found && serial_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    busy         = state == BUSY;
    serial_ready = busy ? n_ch'(1) << grant : '0;
    shift_n      = {serial_data[grant], shift[width-1:1]};
    acc          = busy && serial_valid[grant];
    done         = acc && bit_cnt == bw'(width - 1);
    // the gap cycle that would bring the idle count up to timeout is the abort edge
    abort        = timeout > 0 && busy && !serial_valid[grant] && idle_cnt == iw'(timeout - 1);
    state_n      = state == IDLE ? (found ? BUSY : IDLE) : (done || abort ? IDLE : BUSY);
  end

  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else      state <= state_n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant          <= '0;
      last_grant     <= cw'(n_ch - 1);
      shift          <= '0;
      bit_cnt        <= '0;
      idle_cnt       <= '0;
      parallel_valid <= 1'b0;
      parallel_data  <= '0;
      parallel_ch    <= '0;
      err            <= 1'b0;
      err_ch         <= '0;
    end else begin
      parallel_valid <= done;
      err            <= abort;
      if (state == IDLE && found) begin
        grant      <= pick;
        last_grant <= pick;
      end
      if (acc) begin
        shift    <= shift_n;
        bit_cnt  <= done ? '0 : bit_cnt + 1'b1;
        idle_cnt <= '0;
      end else if (busy) idle_cnt <= idle_cnt + 1'b1;
      if (done) begin
        parallel_data <= shift_n;
        parallel_ch   <= grant;
      end
      if (abort) begin
        shift    <= '0;
        bit_cnt  <= '0;
        idle_cnt <= '0;
        err_ch   <= grant;
      end
    end
  end
endmodule

// File: tb/tb_serial_word_arbiter.sv
// tb_serial_word_arbiter: directed checks of arbitration, assembly, gaps, timeout, reset and isolation
module tb_serial_word_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] serial_valid, serial_data, serial_ready;
  logic       busy, parallel_valid, err;
  logic [7:0] parallel_data;
  logic [1:0] parallel_ch, err_ch;

  logic [7:0] word [4];
  logic [2:0] ptr  [4];
  logic [3:0] en = '0;
  logic       tog = 1'b0;
  int         cyc = 0, pv_cnt = 0, err_cnt = 0;
  int         n_assert = 0, n_fail = 0;
  int         n, pv0, err0;
  logic [2:0] p1;

  serial_word_arbiter #(.width(8), .n_ch(4), .timeout(16)) dut (
    .clk(clk), .rst(rst), .serial_valid(serial_valid), .serial_data(serial_data),
    .serial_ready(serial_ready), .busy(busy), .parallel_valid(parallel_valid),
    .parallel_data(parallel_data), .parallel_ch(parallel_ch), .err(err), .err_ch(err_ch));

  always #5 clk = ~clk;

  // requester model: each lane presents word[c] LSB-first, advancing on its own handshake
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      serial_valid[c] = en[c];
      serial_data[c]  = word[c][ptr[c]];
    end
    if (tog) begin
      serial_valid[1] = cyc[0];
      serial_data[1]  = cyc[1];
    end
  end

  always @(posedge clk)
    for (int c = 0; c < 4; c++)
      if (!rst) ptr[c] <= '0;
      else if (serial_valid[c] && serial_ready[c]) ptr[c] <= ptr[c] + 3'd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      check("ready_onehot0", 32'($onehot0(serial_ready)), 32'd1);
      check("pv_err_overlap", 32'(parallel_valid && err), 32'd0);
    end
    if (parallel_valid) pv_cnt <= pv_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pv(output int k);
    k = 0;
    do begin tick(); k++; end while (!parallel_valid && k < 60);
  endtask

  task automatic wait_err(output int k);
    k = 0;
    do begin tick(); k++; end while (!err && k < 60);
  endtask

  initial begin
    word = '{8'h5A, 8'hA5, 8'h3C, 8'h0F};
    tick(); tick();
    check("rst_ready", 32'(serial_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pv", 32'(parallel_valid), 0);
    check("rst_pdata", 32'(parallel_data), 0);
    check("rst_pch", 32'(parallel_ch), 0);
    check("rst_err", 32'(err), 0);
    check("rst_errch", 32'(err_ch), 0);
    rst = 1'b1;
    tick();

    // single word on ch1
    en[1] = 1'b1;
    tick();
    check("single_busy", 32'(busy), 1);
    check("single_ready", 32'(serial_ready), 32'h2);
    wait_pv(n);
    en[1] = 1'b0;
    check("single_lat", n, 8);
    check("single_data", 32'(parallel_data), 32'hA5);
    check("single_ch", 32'(parallel_ch), 1);
    tick();
    check("single_idle", 32'(busy), 0);
    check("single_pv_pulse", 32'(parallel_valid), 0);
    check("single_hold", 32'(parallel_data), 32'hA5);

    // round robin from a fresh reset
    word = '{8'h5A, 8'hC3, 8'h96, 8'h0F};
    rst = 1'b0; en = 4'hF;
    tick();
    rst = 1'b1;
    wait_pv(n);
    check("rr_first_lat", n, 9);
    check("rr_ch0", 32'(parallel_ch), 0);
    check("rr_d0", 32'(parallel_data), 32'h5A);
    wait_pv(n);
    check("rr_gap1", n, 9);
    check("rr_ch1", 32'(parallel_ch), 1);
    check("rr_d1", 32'(parallel_data), 32'hC3);
    wait_pv(n);
    check("rr_gap2", n, 9);
    check("rr_ch2", 32'(parallel_ch), 2);
    check("rr_d2", 32'(parallel_data), 32'h96);
    wait_pv(n);
    check("rr_gap3", n, 9);
    check("rr_ch3", 32'(parallel_ch), 3);
    check("rr_d3", 32'(parallel_data), 32'h0F);
    wait_pv(n);
    en = '0;
    check("rr_gap4", n, 9);
    check("rr_ch0b", 32'(parallel_ch), 0);
    tick();

    // gapped word on ch2
    word[2] = 8'h3C;
    err0 = err_cnt;
    en[2] = 1'b1;
    repeat (5) tick();
    en[2] = 1'b0;
    repeat (3) tick();
    check("gap_still_busy", 32'(busy), 1);
    en[2] = 1'b1;
    wait_pv(n);
    en[2] = 1'b0;
    check("gap_lat", n, 4);
    check("gap_data", 32'(parallel_data), 32'h3C);
    check("gap_ch", 32'(parallel_ch), 2);
    tick();
    check("gap_no_err", err_cnt - err0, 0);

    // timeout on ch3 while ch0 waits
    word[3] = 8'hFF; word[0] = 8'h81;
    en[3] = 1'b1; en[0] = 1'b1;
    tick();
    check("to_grant3", 32'(serial_ready), 32'h8);
    repeat (5) tick();
    en[3] = 1'b0;
    pv0 = pv_cnt;
    wait_err(n);
    check("to_lat", n, 16);
    check("to_errch", 32'(err_ch), 3);
    check("to_no_pv", pv_cnt - pv0, 0);
    check("to_pdata_hold", 32'(parallel_data), 32'h3C);
    tick();
    check("to_err_pulse", 32'(err), 0);
    check("to_grant0", 32'(serial_ready), 32'h1);
    check("to_errch_hold", 32'(err_ch), 3);
    wait_pv(n);
    check("to_next_lat", n, 8);
    check("to_next_data", 32'(parallel_data), 32'h81);
    check("to_next_ch", 32'(parallel_ch), 0);

    // reset in the middle of a ch0 word
    word[0] = 8'hFF;
    tick();
    repeat (4) tick();
    pv0 = pv_cnt; err0 = err_cnt;
    rst = 1'b0;
    tick();
    word[0] = 8'h12;
    check("mrst_ready", 32'(serial_ready), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_pdata", 32'(parallel_data), 0);
    check("mrst_pch", 32'(parallel_ch), 0);
    check("mrst_errch", 32'(err_ch), 0);
    rst = 1'b1;
    wait_pv(n);
    en[0] = 1'b0;
    check("mrst_lat", n, 9);
    check("mrst_data", 32'(parallel_data), 32'h12);
    check("mrst_no_stale", (pv_cnt - pv0) + (err_cnt - err0), 0);
    tick();

    // ch1 toggles while ch0 holds the grant, then ch1 wins fairly
    word[0] = 8'h6E; word[1] = 8'hB4;
    p1 = ptr[1];
    en[0] = 1'b1;
    tick();
    tog = 1'b1;
    wait_pv(n);
    tog = 1'b0; en[1] = 1'b1;
    check("iso_lat", n, 8);
    check("iso_data", 32'(parallel_data), 32'h6E);
    check("iso_ch", 32'(parallel_ch), 0);
    check("iso_ch1_untouched", 32'(ptr[1]), 32'(p1));
    tick();
    check("iso_fair_grant", 32'(serial_ready), 32'h2);
    wait_pv(n);
    en = '0;
    check("iso_ch1_lat", n, 8);
    check("iso_ch1_data", 32'(parallel_data), 32'hB4);
    check("iso_ch1_ch", 32'(parallel_ch), 1);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
